deser: RTL and testbench
========================

DESER -- requirements
Module: deser

Interface
REQ-001 Parameter: WORD_WIDTH, default 8, bits per word; legal range >= 2, non-power-of-two allowed.
REQ-002 Port: clk  input  1  sole clock, all state on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low.
REQ-004 Port: sd  input  1  serial data bit, sampled only when sen=1.
REQ-005 Port: sen  input  1  serial bit strobe; one bit consumed per clk with sen=1.
REQ-006 Port: sync  input  1  word-alignment marker, meaningful only with sen=1.
REQ-007 Port: data  output  WORD_WIDTH  assembled word.
REQ-008 Port: valid  output  1  data holds an unconsumed word.
REQ-009 Port: ready  input  1  consumer accepts data when valid&&ready at clk edge.
REQ-010 Port: overflow  output  1  one-cycle pulse, completed word dropped.

Function
REQ-011 The state machine SHALL have two states: IDLE (no partial word) and ACTIVE (partial word in progress).
REQ-012 Each sen=1 cycle SHALL shift sd into the shift register and increment the bit count; sen=0 cycles SHALL leave all shift state unchanged (gaps allowed, arbitrary length).
REQ-013 Default bit order SHALL be MSB first: the first received bit lands in data[WORD_WIDTH-1].
REQ-014 IDLE->ACTIVE on sen=1; ACTIVE->IDLE on the sen=1 cycle carrying bit WORD_WIDTH-1 (word complete), bit count wrapping to 0.
REQ-015 A completed word SHALL appear on data with valid=1 on the clk after its last sen cycle (latency 1).
REQ-016 valid SHALL stay 1 and data SHALL stay stable until the valid&&ready cycle; valid drops the next cycle unless a new word loads in the same cycle.
REQ-017 Word complete in the same cycle as valid&&ready: new word SHALL load, valid stays 1, no overflow.
REQ-018 Word complete while valid=1 and ready=0: new word SHALL be discarded, held word kept, overflow=1 for exactly the next cycle.
REQ-019 sync=1 with sen=1 SHALL discard any partial word and treat the current sd as bit 0 of a new word; with WORD_WIDTH bits pending this never completes a word early.
REQ-020 sync=1 with sen=0 SHALL be ignored.
REQ-021 The output buffer SHALL be independent of shifting: reception continues while valid=1.

Reset
REQ-022 Asserting rst SHALL immediately force state IDLE, bit count 0, shift register 0, data 0, valid 0, overflow 0.
REQ-023 Reset mid-word SHALL discard the partial word; after release the first sen=1 bit is bit 0.

Configuration
REQ-024 Macro DESER_LSB_FIRST_EN defined: first received bit SHALL land in data[0] (LSB first); undefined: MSB first per REQ-013; all timing identical either way.

Structure
REQ-025 Package serdes_pkg SHALL hold the state_t enum (IDLE, ACTIVE), shared with the serializer.
REQ-026 One sub-module, deser_obuf, SHALL implement the single-entry output register with valid/ready and the overflow pulse.

Verification
REQ-027 sen=1 for 8 cycles, sd=1,0,1,0,0,1,0,1, ready=1 -> data=0xA5, valid=1 one cycle after the 8th bit, valid=0 next cycle.
REQ-028 Same 0xA5 stream with sen=0 gaps of 3 cycles between bits -> same data=0xA5, valid 1 cycle after last bit.
REQ-029 ready=0, send 0x3C then 0xC3 back-to-back -> data stays 0x3C, overflow=1 for one cycle after the 16th bit; ready=1 then drains 0x3C only.
REQ-030 Send 3 bits, then sync=1 with bits of 0x5A -> data=0x5A, no word from the 3 stale bits.
REQ-031 Assert rst after 4 bits of a word, release, send 0xF0 -> data=0xF0; during reset valid=0, data=0.
REQ-032 With DESER_LSB_FIRST_EN, stream 0,0,0,1,1,1,1,0 -> data=0x78; without it -> data=0x1E.

Source files
------------

// File: rtl/serdes_pkg.sv
// rtl/serdes_pkg.sv - shared serializer/deserializer types
package serdes_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/deser_obuf.sv
// rtl/deser_obuf.sv - single-entry output register with valid/ready and overflow pulse
module deser_obuf #(
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WORD_WIDTH-1:0] word,
  output logic [WORD_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  overflow
);

  // A held word is never overwritten; a word arriving into a full, stalled buffer is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data     <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (load) begin
        if (!valid || ready) begin
          data  <= word;
          valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/deser.sv
// rtl/deser.sv - serial-to-parallel deserializer; DESER_LSB_FIRST_EN selects LSB-first bit order
import serdes_pkg::*;

module deser #(
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sd,
  input  logic                  sen,
  input  logic                  sync,
  output logic [WORD_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  overflow
);

  localparam int CW = $clog2(WORD_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WORD_WIDTH - 1);

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
  logic [WORD_WIDTH-1:0] shifted;
  logic [WORD_WIDTH-1:0] seed;
  logic                  complete;

  // seed is the register image of a word whose first bit is the current sd.
`ifdef DESER_LSB_FIRST_EN
  assign shifted = {sd, shreg_q[WORD_WIDTH-1:1]};
  assign seed    = {sd, {(WORD_WIDTH-1){1'b0}}};
`else
  assign shifted = {shreg_q[WORD_WIDTH-2:0], sd};
  assign seed    = {{(WORD_WIDTH-1){1'b0}}, sd};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    complete = 1'b0;
    if (sen) begin
      if (sync || state_q == IDLE) begin
        state_d = ACTIVE;
        cnt_d   = CW'(1);
        shreg_d = seed;
      end else if (cnt_q == LAST) begin
        state_d  = IDLE;
        cnt_d    = '0;
        shreg_d  = shifted;
        complete = 1'b1;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        shreg_d = shifted;
      end
    end
  end

  deser_obuf #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_obuf (
    .clk      (clk),
    .rst      (rst),
    .load     (complete),
    .word     (shifted),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_deser.sv
// tb/tb_deser.sv - directed self-checking bench for deser; honours DESER_LSB_FIRST_EN
module tb_deser;

  logic       clk;
  logic       rst;
  logic       sd;
  logic       sen;
  logic       sync;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       overflow;

  int n_cmp;
  int n_fail;

  deser #(.WORD_WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .sd       (sd),
    .sen      (sen),
    .sync     (sync),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic s);
    @(negedge clk);
    sen  = 1'b1;
    sd   = b;
    sync = s;
  endtask

  task automatic gap();
    @(negedge clk);
    sen  = 1'b0;
    sd   = 1'b0;
    sync = 1'b0;
  endtask

  // Stream order: w[7] first on the wire.
  task automatic send_word(input logic [7:0] w, input logic first_sync);
    for (int i = 7; i >= 0; i--) send_bit(w[i], (i == 7) && first_sync);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b0;
    sd     = 1'b0;
    sen    = 1'b0;
    sync   = 1'b0;
    ready  = 1'b1;

    repeat (2) @(negedge clk);
    check("reset_valid", valid, 0);
    check("reset_data", data, 0);
    check("reset_overflow", overflow, 0);
    rst = 1'b1;

    // 0xA5, continuous strobe (palindromic, so bit order does not matter)
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] w;
      w = 8'hA5;
      send_bit(w[i], 1'b0);
      if (i == 0) check("a5_no_early_valid", valid, 0);
    end
    gap();
    check("a5_valid", valid, 1);
    check("a5_data", data, 8'hA5);
    gap();
    check("a5_valid_drop", valid, 0);

    // 0xA5 with three idle cycles between bits
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] w;
      w = 8'hA5;
      send_bit(w[i], 1'b0);
      if (i > 0) repeat (3) gap();
    end
    gap();
    check("gap_valid", valid, 1);
    check("gap_data", data, 8'hA5);
    gap();
    check("gap_valid_drop", valid, 0);

    // Overflow: 0x3C held, 0xC3 dropped while stalled
    ready = 1'b0;
    send_word(8'h3C, 1'b0);
    send_word(8'hC3, 1'b0);
    check("ovf_quiet_before", overflow, 0);
    gap();
    check("ovf_pulse", overflow, 1);
    check("ovf_held_data", data, 8'h3C);
    check("ovf_held_valid", valid, 1);
    gap();
    check("ovf_pulse_end", overflow, 0);
    check("ovf_still_valid", valid, 1);
    ready = 1'b1;
    gap();
    check("ovf_drained", valid, 0);
    check("ovf_drain_data", data, 8'h3C);

    // Completion in the same cycle as a drain
    ready = 1'b0;
    send_word(8'h81, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] w;
      w = 8'h7E;
      send_bit(w[i], 1'b0);
      if (i == 0) ready = 1'b1;
    end
    gap();
    check("swap_valid", valid, 1);
    check("swap_data", data, 8'h7E);
    check("swap_no_overflow", overflow, 0);
    gap();
    check("swap_drop", valid, 0);

    // Sync realignment after 3 stale bits
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] w;
      w = 8'h5A;
      send_bit(w[i], i == 7);
      if (i == 2) check("sync_no_stale_word", valid, 0);
    end
    gap();
    check("sync_valid", valid, 1);
    check("sync_data", data, 8'h5A);
    gap();

    // sync without sen must be ignored: 4 bits, idle sync, then 4 more bits
    for (int i = 7; i >= 4; i--) begin
      logic [7:0] w;
      w = 8'h99;
      send_bit(w[i], 1'b0);
    end
    @(negedge clk);
    sen  = 1'b0;
    sync = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      logic [7:0] w;
      w = 8'h99;
      send_bit(w[i], 1'b0);
    end
    gap();
    check("idle_sync_valid", valid, 1);
    check("idle_sync_data", data, 8'h99);
    gap();

    // Reset mid-word
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    @(negedge clk);
    sen = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst_valid", valid, 0);
    check("midrst_data", data, 0);
    @(negedge clk);
    rst = 1'b1;
    send_word(8'hF0, 1'b0);
    gap();
    check("postrst_valid", valid, 1);
`ifdef DESER_LSB_FIRST_EN
    check("postrst_data", data, 8'h0F);
`else
    check("postrst_data", data, 8'hF0);
`endif
    gap();

    // Bit order: stream 0,0,0,1,1,1,1,0
    send_word(8'h1E, 1'b0);
    gap();
    check("order_valid", valid, 1);
`ifdef DESER_LSB_FIRST_EN
    check("order_data", data, 8'h78);
`else
    check("order_data", data, 8'h1E);
`endif
    gap();
    check("order_drop", valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
